cp0_timer_bank: RTL and testbench

Parametrised multi-channel CP0 timer block: one shared free-running Count register and NUM_CH independent Compare channels, each with enable, optional periodic auto-reload and a sticky pending flag. It is the next-generation replacement for the single Count/Compare timer inside the CP0 register file. It sits beside the CP0 register file on the same mtc0/mfc0 write/read port, and its pending vector feeds the Cause hardware-interrupt bits.

---
 rtl/cp0_timer_pkg.sv | 20 ++
 rtl/cp0_timer_bank_if.sv | 23 ++
 rtl/cp0_timer_ch.sv | 113 +++++++++++
 rtl/cp0_timer_bank.sv | 136 +++++++++++++
 tb/tb_cp0_timer_bank.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_timer_pkg.sv
// Shared constants for the CP0 timer bank: register numbers, TCTRL bit
// positions and the largest supported channel count.
package cp0_timer_pkg;

    // CP0 register numbers decoded by the timer bank
    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_TCTRL   = 5'd22;
    localparam logic [4:0] CP0_REG_TPERIOD = 5'd23;

    // TCTRL field positions
    localparam int TCTRL_EN       = 0;
    localparam int TCTRL_PERIODIC = 1;
    localparam int TCTRL_PEND     = 2;
    localparam int TCTRL_STOP     = 31;

    // The 3-bit sel field addresses at most eight channels
    localparam int CP0_TIMER_MAX_CH = 8;

endpackage

// File: rtl/cp0_timer_bank_if.sv
// mtc0/mfc0 register port shared with the CP0 register file. The core side
// is the master; the timer bank is the slave and returns combinational read data.
interface cp0_timer_bank_if;

    logic        we_i;
    logic [4:0]  waddr_i;
    logic [2:0]  wsel_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [2:0]  rsel_i;
    logic [31:0] rdata_o;

    modport master (
        output we_i, waddr_i, wsel_i, wdata_i, raddr_i, rsel_i,
        input  rdata_o
    );

    modport slave (
        input  we_i, waddr_i, wsel_i, wdata_i, raddr_i, rsel_i,
        output rdata_o
    );

endinterface

// File: rtl/cp0_timer_ch.sv
// One compare channel: compare value, optional reload period, EN/PERIODIC/PEND
// and the match/reload logic. Auto-reload storage exists only when
// CP0_TIMER_PERIODIC_EN is defined; otherwise the channel is one-shot.
module cp0_timer_ch
    import cp0_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_i,
    input  logic             cmp_we_i,
    input  logic             ctrl_we_i,
    input  logic             period_we_i,
    input  logic [CNT_W-1:0] wval_i,
    input  logic [2:0]       wctrl_i,
    output logic [CNT_W-1:0] compare_o,
    output logic [CNT_W-1:0] period_o,
    output logic             en_o,
    output logic             periodic_o,
    output logic             pend_o,
    output logic             intr_o
);

    logic [CNT_W-1:0] compare_q, compare_d;
    logic             en_q, en_d;
    logic             pend_q, pend_d;
    logic             match;

`ifdef CP0_TIMER_PERIODIC_EN
    logic [CNT_W-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;

    // Next-state for the reload period and the PERIODIC mode bit
    always_comb begin
        period_d   = period_we_i ? wval_i : period_q;
        periodic_d = ctrl_we_i ? wctrl_i[TCTRL_PERIODIC] : periodic_q;
    end

    // Reload configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            period_q   <= period_d;
            periodic_q <= periodic_d;
        end
    end

    assign period_o   = period_q;
    assign periodic_o = periodic_q;
`else
    assign period_o   = '0;
    assign periodic_o = 1'b0;

    logic unused_periodic;
    assign unused_periodic = period_we_i ^ wctrl_i[TCTRL_PERIODIC];
`endif

    // A disabled channel never raises a match
    always_comb match = en_q && (count_i == compare_q);

    // Next-state: software writes, periodic reload, sticky pending
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        compare_d = compare_q;
        en_d      = en_q;
        pend_d    = pend_q;

        // A COMPARE write wins over the reload value computed the same cycle
        if (cmp_we_i) begin
            compare_d = wval_i;
        end else if (match && periodic_o) begin
            compare_d = compare_q + period_o;
        end

        if (ctrl_we_i) begin
            en_d = wctrl_i[TCTRL_EN];
        end

        // Clears (COMPARE write, PEND write-1) lose to a simultaneous match
        if (match) begin
            pend_d = 1'b1;
        end else if (cmp_we_i || (ctrl_we_i && wctrl_i[TCTRL_PEND])) begin
            pend_d = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here holds architectural state the core can read,
        // so all of them are cleared by the async reset.
        if (!rst_n) begin
            compare_q <= '0;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            compare_q <= compare_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
        end
    end

    assign compare_o = compare_q;
    assign en_o      = en_q;
    assign pend_o    = pend_q;
    assign intr_o    = pend_q & en_q;

endmodule

// File: rtl/cp0_timer_bank.sv
// Multi-channel CP0 timer: one free-running Count (with STOP), NUM_CH compare
// channels, CP0 write decode and the combinational read mux.
// Optional feature macro: CP0_TIMER_PERIODIC_EN enables TPERIOD and auto-reload.
module cp0_timer_bank
    import cp0_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cp0_timer_bank_if.slave     bus_if,
    output logic [CNT_W-1:0]    count_o,
    output logic [NUM_CH-1:0]   timer_intr_o,
    output logic                timer_any_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             stop_q, stop_d;

    logic wr_count, wr_cmp, wr_ctrl, wr_period;

    // Channel state padded out to eight entries; absent channels read as zero
    logic [CP0_TIMER_MAX_CH-1:0][CNT_W-1:0] cmp_arr;
    logic [CP0_TIMER_MAX_CH-1:0][CNT_W-1:0] per_arr;
    logic [CP0_TIMER_MAX_CH-1:0]            en_vec;
    logic [CP0_TIMER_MAX_CH-1:0]            periodic_vec;
    logic [CP0_TIMER_MAX_CH-1:0]            pend_vec;
    logic [NUM_CH-1:0]                      intr_vec;
    logic [31:0]                            rdata;

    // Register-number decode of the mtc0 port
    always_comb begin
        wr_count  = bus_if.we_i && (bus_if.waddr_i == CP0_REG_COUNT);
        wr_cmp    = bus_if.we_i && (bus_if.waddr_i == CP0_REG_COMPARE);
        wr_ctrl   = bus_if.we_i && (bus_if.waddr_i == CP0_REG_TCTRL);
        wr_period = bus_if.we_i && (bus_if.waddr_i == CP0_REG_TPERIOD);
    end

    // Count next-state: a COUNT write overrides the increment; STOP freezes it
    always_comb begin
        count_d = count_q;
        stop_d  = stop_q;
        if (wr_count) begin
            count_d = bus_if.wdata_i[CNT_W-1:0];
        end else if (!stop_q) begin
            count_d = count_q + CNT_W'(1);
        end
        if (wr_ctrl && (bus_if.wsel_i == 3'd0)) begin
            stop_d = bus_if.wdata_i[TCTRL_STOP];
        end
    end

    // Shared Count and STOP registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            stop_q  <= stop_d;
        end
    end

    // Compare channels; sel values at or above NUM_CH hit no channel
    for (genvar g = 0; g < CP0_TIMER_MAX_CH; g++) begin : g_ch
        if (g < NUM_CH) begin : g_live
            cp0_timer_ch #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .count_i     (count_q),
                .cmp_we_i    (wr_cmp    && (bus_if.wsel_i == 3'(g))),
                .ctrl_we_i   (wr_ctrl   && (bus_if.wsel_i == 3'(g))),
                .period_we_i (wr_period && (bus_if.wsel_i == 3'(g))),
                .wval_i      (bus_if.wdata_i[CNT_W-1:0]),
                .wctrl_i     (bus_if.wdata_i[2:0]),
                .compare_o   (cmp_arr[g]),
                .period_o    (per_arr[g]),
                .en_o        (en_vec[g]),
                .periodic_o  (periodic_vec[g]),
                .pend_o      (pend_vec[g]),
                .intr_o      (intr_vec[g])
            );
        end else begin : g_pad
            assign cmp_arr[g]      = '0;
            assign per_arr[g]      = '0;
            assign en_vec[g]       = 1'b0;
            assign periodic_vec[g] = 1'b0;
            assign pend_vec[g]     = 1'b0;
        end
    end

    // Combinational read mux; narrow registers are zero-extended to 32 bits
    always_comb begin
        rdata = '0;
        case (bus_if.raddr_i)
            CP0_REG_COUNT: begin
                rdata[CNT_W-1:0] = count_q;
            end
            CP0_REG_COMPARE: begin
                rdata[CNT_W-1:0] = cmp_arr[bus_if.rsel_i];
            end
            CP0_REG_TCTRL: begin
                rdata[TCTRL_EN]       = en_vec[bus_if.rsel_i];
                rdata[TCTRL_PERIODIC] = periodic_vec[bus_if.rsel_i];
                rdata[TCTRL_PEND]     = pend_vec[bus_if.rsel_i];
                rdata[TCTRL_STOP]     = stop_q && (bus_if.rsel_i == 3'd0);
            end
`ifdef CP0_TIMER_PERIODIC_EN
            CP0_REG_TPERIOD: begin
                rdata[CNT_W-1:0] = per_arr[bus_if.rsel_i];
            end
`endif
            default: begin
                rdata = '0;
            end
        endcase
    end

    assign bus_if.rdata_o = rdata;
    assign count_o        = count_q;
    assign timer_intr_o   = intr_vec;
    assign timer_any_o    = |intr_vec;

    // Write-data bits above the register width and unused TCTRL bits are dropped
    logic unused_wdata;
    assign unused_wdata = ^bus_if.wdata_i;

`ifndef CP0_TIMER_PERIODIC_EN
    logic unused_period;
    assign unused_period = ^per_arr;
`endif

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Self-checking bench for cp0_timer_bank (NUM_CH=3, CNT_W=16): directed
// scenarios with literal expectations plus a randomized phase, all compared
// every cycle against a rule-level model of the timer bank.
module tb_cp0_timer_bank;
    import cp0_timer_pkg::*;

    localparam int          NCH  = 3;
    localparam int          CW   = 16;
    localparam int unsigned MASK = 32'h0000_FFFF;
`ifdef CP0_TIMER_PERIODIC_EN
    localparam bit PER_ON = 1'b1;
`else
    localparam bit PER_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cp0_timer_bank_if bus_if ();
    logic [CW-1:0]  count_o;
    logic [NCH-1:0] timer_intr_o;
    logic           timer_any_o;

    cp0_timer_bank #(
        .NUM_CH (NCH),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_if       (bus_if),
        .count_o      (count_o),
        .timer_intr_o (timer_intr_o),
        .timer_any_o  (timer_any_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_cnt = 0;
    bit          m_stop = 0;
    int unsigned m_cmp [NCH] = '{default: 0};
    int unsigned m_per [NCH] = '{default: 0};
    bit          m_en  [NCH] = '{default: 0};
    bit          m_pf  [NCH] = '{default: 0};
    bit          m_pend[NCH] = '{default: 0};
    bit          m_hit [NCH];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cnt = 0;
            m_stop = 0;
            for (int c = 0; c < NCH; c++) begin
                m_cmp[c] = 0; m_per[c] = 0; m_en[c] = 0; m_pf[c] = 0; m_pend[c] = 0;
            end
        end else begin
            logic [31:0] w;
            logic [4:0]  a;
            int          s;
            bit          we;
            w  = bus_if.wdata_i;
            a  = bus_if.waddr_i;
            s  = int'(bus_if.wsel_i);
            we = bus_if.we_i;
            for (int c = 0; c < NCH; c++) m_hit[c] = m_en[c] && (m_cnt == m_cmp[c]);
            for (int c = 0; c < NCH; c++) begin
                bit mine;
                mine = we && (s == c);
                if (mine && a == CP0_REG_COMPARE) begin
                    m_cmp[c]  = w & MASK;
                    m_pend[c] = 0;
                end else if (m_hit[c] && m_pf[c]) begin
                    m_cmp[c] = (m_cmp[c] + m_per[c]) & MASK;
                end
                if (mine && a == CP0_REG_TCTRL) begin
                    m_en[c] = w[0];
                    m_pf[c] = PER_ON && w[1];
                    if (w[2]) m_pend[c] = 0;
                end
                if (mine && a == CP0_REG_TPERIOD && PER_ON) m_per[c] = w & MASK;
                if (m_hit[c]) m_pend[c] = 1;
            end
            if (we && a == CP0_REG_COUNT) m_cnt = w & MASK;
            else if (!m_stop)             m_cnt = (m_cnt + 1) & MASK;
            if (we && a == CP0_REG_TCTRL && s == 0) m_stop = w[31];
        end
    end

    function automatic logic [31:0] m_rdata(input logic [4:0] a, input int s);
        logic [31:0] r;
        r = '0;
        if (a == CP0_REG_COUNT) begin
            r = m_cnt;
        end else if (a == CP0_REG_COMPARE && s < NCH) begin
            r = m_cmp[s];
        end else if (a == CP0_REG_TCTRL) begin
            if (s < NCH) r = {29'd0, m_pend[s], m_pf[s], m_en[s]};
            if (s == 0 && m_stop) r[31] = 1'b1;
        end else if (a == CP0_REG_TPERIOD && s < NCH && PER_ON) begin
            r = m_per[s];
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] m_intr();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c] && m_en[c];
        return v;
    endfunction

    // Per-cycle comparison on the falling edge
    initial forever begin
        @(negedge clk);
        check("cyc_count", 32'(count_o), m_cnt);
        check("cyc_intr", 32'(timer_intr_o), 32'(m_intr()));
        check("cyc_any", 32'(timer_any_o), 32'(|m_intr()));
        check("cyc_rdata", bus_if.rdata_o, m_rdata(bus_if.raddr_i, int'(bus_if.rsel_i)));
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus_if.we_i    = 1'b1;
        bus_if.waddr_i = a;
        bus_if.wsel_i  = s;
        bus_if.wdata_i = d;
        @(posedge clk);
        #1;
        bus_if.we_i = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] exp);
        bus_if.raddr_i = a;
        bus_if.rsel_i  = s;
        @(negedge clk);
        check(name, bus_if.rdata_o, exp);
        @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge where count_o equals v
    task automatic wait_count(input logic [CW-1:0] v, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (count_o == v) found = 1'b1;
        end
        if (!found) check("wait_count", 32'(count_o), 32'(v));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.we_i    = 1'b0;
        bus_if.waddr_i = '0;
        bus_if.wsel_i  = '0;
        bus_if.wdata_i = '0;
        bus_if.raddr_i = CP0_REG_TCTRL;
        bus_if.rsel_i  = 3'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_intr", 32'(timer_intr_o), 32'd0);
        check("rst_any", 32'(timer_any_o), 32'd0);
        check("rst_tctrl", bus_if.rdata_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // One-shot match and clear by COMPARE write
        wr(CP0_REG_COMPARE, 3'd0, 32'h20);
        wr(CP0_REG_TCTRL, 3'd0, 32'h1);
        wr(CP0_REG_COUNT, 3'd0, 32'h0);
        wait_count(16'h20, 100);
        check("t1_before_match", 32'(timer_intr_o[0]), 32'd0);
        wait_count(16'h21, 4);
        check("t1_intr_hi", 32'(timer_intr_o[0]), 32'd1);
        check("t1_any_hi", 32'(timer_any_o), 32'd1);
        step(1);
        wr(CP0_REG_COMPARE, 3'd0, 32'h40);
        check("t1_intr_clr", 32'(timer_intr_o[0]), 32'd0);

        // Periodic reload on channel 1
        wr(CP0_REG_COMPARE, 3'd1, 32'h10);
        wr(CP0_REG_TPERIOD, 3'd1, 32'h8);
        wr(CP0_REG_TCTRL, 3'd1, 32'h3);
        wr(CP0_REG_COUNT, 3'd0, 32'h0);
        wait_count(16'h11, 40);
        check("t2_first_hit", 32'(timer_intr_o[1]), 32'd1);
        step(1);
        rd_check("t2_cmp_reload", CP0_REG_COMPARE, 3'd1, PER_ON ? 32'h18 : 32'h10);
        wr(CP0_REG_TCTRL, 3'd1, 32'h7);
        check("t2_w1c", 32'(timer_intr_o[1]), 32'd0);
        wait_count(16'h19, 40);
        check("t2_second_hit", 32'(timer_intr_o[1]), 32'(PER_ON));
        step(1);
        wr(CP0_REG_TCTRL, 3'd1, 32'h7);
        wait_count(16'h21, 40);
        check("t2_third_hit", 32'(timer_intr_o[1]), 32'(PER_ON));
        step(1);

        // Match in the same cycle as PEND write-1-clear
        wr(CP0_REG_COMPARE, 3'd0, 32'h100);
        wr(CP0_REG_COUNT, 3'd0, 32'h100);
        wr(CP0_REG_TCTRL, 3'd0, 32'h5);
        check("t3_match_beats_w1c", 32'(timer_intr_o[0]), 32'd1);

        // COMPARE write in the same cycle as a periodic match
        wr(CP0_REG_COMPARE, 3'd1, 32'h200);
        wr(CP0_REG_COUNT, 3'd0, 32'h200);
        wr(CP0_REG_COMPARE, 3'd1, 32'hABCD_0300);
        check("t3_match_beats_cmpwr", 32'(timer_intr_o[1]), 32'd1);
        rd_check("t3_cmp_write_wins", CP0_REG_COMPARE, 3'd1, 32'h300);
        wr(CP0_REG_TCTRL, 3'd1, 32'h4);

        // Count wrap at 16 bits
        wr(CP0_REG_COMPARE, 3'd2, 32'h1);
        wr(CP0_REG_TCTRL, 3'd2, 32'h1);
        wr(CP0_REG_COUNT, 3'd0, 32'hFFFE);
        wait_count(16'hFFFF, 4);
        wait_count(16'h0000, 2);
        wait_count(16'h0001, 2);
        check("t4_no_early", 32'(timer_intr_o[2]), 32'd0);
        wait_count(16'h0002, 2);
        check("t4_wrap_hit", 32'(timer_intr_o[2]), 32'd1);
        step(1);
        rd_check("t4_count_zext", CP0_REG_COUNT, 3'd5, 32'h3);

        // STOP freezes Count; a COUNT write still loads
        wr(CP0_REG_TCTRL, 3'd0, 32'h8000_0001);
        wr(CP0_REG_COUNT, 3'd0, 32'h1234);
        step(5);
        check("t5_frozen", 32'(count_o), 32'h1234);
        bus_if.raddr_i = CP0_REG_TCTRL;
        bus_if.rsel_i  = 3'd0;
        @(negedge clk);
        check("t5_stop_rd0", 32'(bus_if.rdata_o[31]), 32'd1);
        bus_if.rsel_i = 3'd1;
        #1;
        check("t5_stop_rd1", 32'(bus_if.rdata_o[31]), 32'd0);
        @(posedge clk);
        #1;
        wr(CP0_REG_TCTRL, 3'd0, 32'h1);
        check("t5_unstop_edge", 32'(count_o), 32'h1234);
        step(2);
        check("t5_running", 32'(count_o), 32'h1236);

        // Out-of-range sel and unmapped register
        wr(CP0_REG_COMPARE, 3'd3, 32'h55);
        rd_check("t6_sel3_rd", CP0_REG_COMPARE, 3'd3, 32'h0);
        rd_check("t6_ch0_intact", CP0_REG_COMPARE, 3'd0, 32'h100);
        rd_check("t6_sel7_tctrl", CP0_REG_TCTRL, 3'd7, 32'h0);
        rd_check("t6_unmapped", 5'd1, 3'd0, 32'h0);

        // EN=0: equality never raises PEND
        wr(CP0_REG_TCTRL, 3'd2, 32'h4);
        wr(CP0_REG_COMPARE, 3'd2, 32'h500);
        wr(CP0_REG_COUNT, 3'd0, 32'h4F0);
        wait_count(16'h502, 40);
        check("t7_disabled", 32'(timer_intr_o[2]), 32'd0);
        step(1);
        rd_check("t7_no_pend", CP0_REG_TCTRL, 3'd2, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int          k;
            logic [31:0] d;
            logic [4:0]  addrs [5];
            addrs = '{CP0_REG_COUNT, CP0_REG_COMPARE, CP0_REG_TCTRL, CP0_REG_TPERIOD, 5'd0};
            addrs[4] = 5'($urandom);
            bus_if.raddr_i = addrs[$urandom_range(0, 4)];
            bus_if.rsel_i  = 3'($urandom_range(0, 3));
            bus_if.we_i    = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 9);
                d = $urandom;
                bus_if.we_i   = 1'b1;
                bus_if.wsel_i = 3'($urandom_range(0, 3));
                if (k == 0) begin
                    bus_if.waddr_i = CP0_REG_COUNT;
                    if ($urandom_range(0, 1) == 0) d[15:0] = 16'hFFF0 | 16'($urandom_range(0, 15));
                end else if (k <= 3) begin
                    bus_if.waddr_i = CP0_REG_COMPARE;
                    d[15:0] = 16'((m_cnt + $urandom_range(0, 24)) & MASK);
                end else if (k <= 6) begin
                    bus_if.waddr_i = CP0_REG_TCTRL;
                    d[31] = ($urandom_range(0, 15) == 0);
                end else if (k <= 8) begin
                    bus_if.waddr_i = CP0_REG_TPERIOD;
                    d[15:0] = 16'($urandom_range(0, 16));
                end else begin
                    bus_if.waddr_i = 5'($urandom);
                end
                bus_if.wdata_i = d;
            end
            @(posedge clk);
            #1;
        end
        bus_if.we_i = 1'b0;

        // Async reset with an interrupt pending
        wr(CP0_REG_COMPARE, 3'd0, 32'h700);
        wr(CP0_REG_TCTRL, 3'd0, 32'h1);
        wr(CP0_REG_COUNT, 3'd0, 32'h700);
        step(1);
        check("t8_pending", 32'(timer_intr_o[0]), 32'd1);
        bus_if.raddr_i = CP0_REG_COMPARE;
        bus_if.rsel_i  = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_count", 32'(count_o), 32'd0);
        check("t8_rst_intr", 32'(timer_intr_o), 32'd0);
        check("t8_rst_any", 32'(timer_any_o), 32'd0);
        check("t8_rst_rdata", bus_if.rdata_o, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("t8_resume", 32'(count_o), 32'd3);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
